// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pulls one byte per frame from the byte FIFO
// and shifts it out LSB first with optional parity and one or two stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] fifo_out,
  input  logic       fifo_empty,
  output logic       fifo_re,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic HAS_PAR   = (PARITY != 0);
  localparam logic ODD_PAR   = (PARITY == 2);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PAR, STOP} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud_cnt, baud_n;
  logic [2:0]      bit_cnt, bit_n;
  logic            stop_cnt, stop_n;
  logic [7:0]      shift_reg, shift_n;
  logic            par_bit, par_n;
  logic            re_n, txd_n, busy_n, done_n;
  logic            bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      fifo_re   <= 1'b0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      stop_cnt  <= stop_n;
      shift_reg <= shift_n;
      par_bit   <= par_n;
      fifo_re   <= re_n;
      txd       <= txd_n;
      busy      <= busy_n;
      tx_done   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    stop_n  = stop_cnt;
    shift_n = shift_reg;
    par_n   = par_bit;
    // The baud counter only runs while a bit is actually on the line
    if (state inside {START, DATA, PAR, STOP})
      baud_n = bit_end ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE:  if (enable && !fifo_empty) state_n = FETCH;
      FETCH: state_n = LOAD;
      LOAD: begin
        shift_n = fifo_out;
        par_n   = (^fifo_out) ^ ODD_PAR;
        baud_n  = '0;
        bit_n   = '0;
        stop_n  = 1'b0;
        state_n = START;
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        shift_n = {1'b0, shift_reg[7:1]};
        bit_n   = bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) state_n = HAS_PAR ? PAR : STOP;
      end
      PAR: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        if (stop_cnt == STOP_LAST) state_n = IDLE;
        else stop_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the upcoming state
  always_comb begin
    re_n   = (state == IDLE) && (state_n == FETCH);
    busy_n = (state_n != IDLE);
    done_n = (state == STOP) && (state_n == IDLE);
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      PAR:     txd_n = par_n;
      default: txd_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parameterisations fed by behavioural FIFOs,
// every cycle compared against a frame-timing model built from the bit rules.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] en  = 3'b000;
  logic [2:0] empty, re, txd, busy, done;
  logic [7:0] fout [3];
  logic [7:0] mem [3][64];
  logic [5:0] rptr [3] = '{6'd0, 6'd0, 6'd0};
  logic [5:0] wptr [3];
  logic [7:0] expQ [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .enable(en[0]), .fifo_out(fout[0]), .fifo_empty(empty[0]),
    .fifo_re(re[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(done[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .fifo_out(fout[1]), .fifo_empty(empty[1]),
    .fifo_re(re[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(done[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(5), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .enable(en[2]), .fifo_out(fout[2]), .fifo_empty(empty[2]),
    .fifo_re(re[2]), .txd(txd[2]), .busy(busy[2]), .tx_done(done[2]));

  assign empty[0] = (rptr[0] == wptr[0]);
  assign empty[1] = (rptr[1] == wptr[1]);
  assign empty[2] = (rptr[2] == wptr[2]);

  // FIFO read data is only meaningful the cycle after a read; otherwise it is junk
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (re[i]) begin
        fout[i] <= mem[i][rptr[i]];
        rptr[i] <= rptr[i] + 6'd1;
      end else begin
        fout[i] <= 8'($urandom);
      end
    end
  end

  function automatic int cpbOf(input int idx);
    return (idx == 2) ? 5 : 4;
  endfunction

  function automatic int parOf(input int idx);
    return idx;
  endfunction

  function automatic int stopOf(input int idx);
    return (idx == 1) ? 2 : 1;
  endfunction

  function automatic int nBits(input int idx);
    return 1 + 8 + ((parOf(idx) != 0) ? 1 : 0) + stopOf(idx);
  endfunction

  // Line level of frame position pos: start, 8 data LSB first, parity, stops
  function automatic logic expBit(input int idx, input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (parOf(idx) != 0 && pos == 9)
      return 1'(($countones(b) % 2) ^ ((parOf(idx) == 2) ? 1 : 0));
    return 1'b1;
  endfunction

  task automatic pushByte(input int idx, input logic [7:0] b);
    mem[idx][wptr[idx]] = b;
    wptr[idx] = wptr[idx] + 6'd1;
    expQ.push_back(b);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input int idx, input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s inst%0d c%0d {re,busy,txd,done}", tag, idx, k),
                  {4'b0, re[idx], busy[idx], txd[idx], done[idx]}, 8'h02);
    end
  endtask

  // Raises enable at the current negedge and checks n frames cycle by cycle.
  // Optionally drops enable or pulses reset at a given cycle offset.
  task automatic applyStimulus(input int idx, input int n, input int tail,
                               input int dropAt, input int resetAt);
    int cpb, len, j, r;
    logic [7:0] fr [$];
    logic [3:0] exp, obs;
    cpb = cpbOf(idx);
    len = 3 + nBits(idx) * cpb;
    for (int i = 0; i < n; i++) fr.push_back(expQ.pop_front());
    en[idx] = 1'b1;
    for (int k = 1; k <= n * len + tail; k++) begin
      @(negedge clk);
      j = (k - 1) / len;
      r = k - j * len;
      if (k > n * len)    exp = 4'b0010;
      else if (r == 1)    exp = 4'b1110;
      else if (r == 2)    exp = 4'b0110;
      else if (r == len)  exp = 4'b0011;
      else                exp = {2'b01, expBit(idx, fr[j], (r - 3) / cpb), 1'b0};
      obs = {re[idx], busy[idx], txd[idx], done[idx]};
      checkOutput($sformatf("inst%0d frame%0d k%0d {re,busy,txd,done}", idx, j, k),
                  {4'b0, obs}, {4'b0, exp});
      if (k == dropAt) en[idx] = 1'b0;
      if (k == resetAt) begin
        rst = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("inst%0d after reset {re,busy,txd,done}", idx),
                    {4'b0, re[idx], busy[idx], txd[idx], done[idx]}, 8'h02);
        rst = 1'b1;
        return;
      end
    end
    en[idx] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) wptr[i] = 6'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("reset inst%0d {re,busy,txd,done}", i),
                  {4'b0, re[i], busy[i], txd[i], done[i]}, 8'h02);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single frame 0xA5, no parity");
    pushByte(0, 8'hA5);
    applyStimulus(0, 1, 4, -1, -1);

    $display("[TB] parity frames");
    pushByte(1, 8'hA5);
    applyStimulus(1, 1, 3, -1, -1);
    pushByte(1, 8'h07);
    applyStimulus(1, 1, 3, -1, -1);
    pushByte(2, 8'hA5);
    applyStimulus(2, 1, 3, -1, -1);

    $display("[TB] back-to-back 0x00, 0xFF with two stop bits");
    pushByte(1, 8'h00);
    pushByte(1, 8'hFF);
    applyStimulus(1, 2, 4, -1, -1);

    $display("[TB] empty FIFO and disabled reads");
    en[0] = 1'b1;
    checkIdle(0, 100, "empty");
    en[0] = 1'b0;
    pushByte(0, 8'($urandom));
    checkIdle(0, 20, "disabled");
    applyStimulus(0, 1, 3, -1, -1);

    $display("[TB] reset during data bit 3");
    pushByte(0, 8'($urandom));
    pushByte(0, 8'($urandom));
    applyStimulus(0, 1, 0, -1, 20);
    applyStimulus(0, 1, 4, -1, -1);

    $display("[TB] enable dropped during start bit");
    pushByte(1, 8'($urandom));
    pushByte(1, 8'($urandom));
    applyStimulus(1, 1, 20, 5, -1);
    applyStimulus(1, 1, 3, -1, -1);

    $display("[TB] random bursts");
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 3; b++) pushByte(i, 8'($urandom));
      applyStimulus(i, 3, 5, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's 8-entry byte FIFO. It drains bytes through the FIFO read port (re/empty/out) and serialises each byte as an asynchronous UART frame on txd. The frame is LSB first, with optional parity and 1 or 2 stop bits. It sits between the FIFO output and the board TX pin.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range >= 2
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-low reset; rst=0 at a posedge resets
enable  in  1  permits starting a new frame; sampled only in IDLE
fifo_out  in  8  FIFO read data; valid the cycle after fifo_re is high at a posedge
fifo_empty  in  1  FIFO empty flag
fifo_re  out  1  FIFO read strobe; registered, single-cycle pulse
txd  out  1  serial output; idle high
busy  out  1  registered; 1 whenever state != IDLE
tx_done  out  1  registered one-cycle pulse after the final stop bit

Behaviour:
- Reset (rst=0 at posedge):
  - State becomes IDLE; txd=1, fifo_re=0, busy=0, tx_done=0.
  - Bit counter and baud counter clear.
  - A frame in flight is abandoned and its byte is lost.
- States: IDLE, FETCH, LOAD, START, DATA, PAR, STOP.
- IDLE:
  - txd=1.
  - If enable=1 and fifo_empty=0: fifo_re<=1, go to FETCH. Otherwise remain.
- FETCH (one cycle): fifo_re is high during this cycle; fifo_re<=0; go to LOAD.
- LOAD (one cycle):
  - shift_reg<=fifo_out; parity accumulator <= ^fifo_out (inverted for odd).
  - txd<=0, go to START.
- Start-bit timing: txd first goes low 3 cycles after the IDLE cycle that saw a non-empty FIFO.
- Bit timing:
  - Each bit (START, each DATA bit, PAR, each STOP) holds txd for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary; its width is $clog2(CLKS_PER_BIT).
- DATA:
  - 8 bits, LSB first; shift right at each bit boundary.
  - A 3-bit counter wraps 7->0 on exit.
  - Exit goes to PAR if PARITY!=0, else to STOP.
- PAR: txd = even parity (XOR of data) or its inverse for odd; one bit time.
- STOP:
  - txd=1 for STOP_BITS bit times.
  - At the end: tx_done<=1 for one cycle, go to IDLE.
- Back-to-back frames: IDLE re-evaluates on the cycle after STOP ends. The minimum high gap between frames is the stop bits plus 3 cycles (IDLE, FETCH, LOAD).
- Enable and FIFO flags during a frame:
  - enable is ignored outside IDLE; deasserting it mid-frame lets the current frame complete.
  - fifo_empty is ignored outside IDLE.
  - fifo_re is never asserted while fifo_empty=1 was sampled.
- fifo_re is never high for two consecutive cycles, and never asserted outside the IDLE->FETCH transition.
- busy is high from FETCH through the last STOP cycle inclusive.
- tx_done is coincident with the first IDLE cycle.
- fifo_out is sampled only in LOAD; changes at other times have no effect.

Test Plan:
1. CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; FIFO holds 0xA5; enable=1 -> one fifo_re pulse; txd 4-cycle bits 0,1,0,1,0,0,1,0,1,1; tx_done pulses once; busy high for 2+40 cycles.
2. PARITY=1 with 0xA5 -> parity bit 0; PARITY=2 with 0xA5 -> 1; PARITY=1 with 0x07 -> 1; frame is 11 bits.
3. FIFO holds 0x00,0xFF back-to-back, STOP_BITS=2 -> two fifo_re pulses; second start bit begins exactly 8+3 cycles after the first frame's stop starts; 0xFF data bits are all 1.
4. fifo_empty=1 with enable=1 for 100 cycles -> fifo_re=0, txd=1, busy=0 throughout; enable=0 with a non-empty FIFO -> no read.
5. rst=0 mid-DATA (bit 3) -> next cycle txd=1, busy=0, fifo_re=0; after release with the FIFO non-empty, a fresh frame starts with a new fifo_re.
6. enable dropped during START -> the frame completes intact; no further fifo_re while enable=0.
